page_table_walker: RTL and testbench

- Hardware page-table walker sitting directly behind the TLB.
- Accepts a TLB miss (virtual address) and walks a two-level page table in RAM over a simple req/ack memory port.
- Returns either a translation (VPN→PPN) or a page fault to the TLB refill port.
- One walk in flight at a time.

---
 rtl/page_table_walker.sv | 182 ++++++++++++++++++
 tb/tb_page_table_walker.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/page_table_walker.sv
// page_table_walker: hardware walker for a two-level page table, placed behind the TLB.
// It takes one TLB miss at a time and reads one PTE per level over a req/ack memory port.
// It returns a translation or a page fault on the refill port.
// Optional feature: define PTW_TIMEOUT_EN to add a watchdog on outstanding memory reads.
module page_table_walker #(
    parameter int addr_width       = 32,
    parameter int page_offset_bits = 12,
    parameter int timeout_cycles   = 255
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [addr_width-page_offset_bits-1:0] ptbr_ppn,
    input  logic                                   flush,
    input  logic                                   miss_valid,
    output logic                                   miss_ready,
    input  logic [addr_width-1:0]                  miss_vaddr,
    output logic                                   mem_req,
    output logic [addr_width-1:0]                  mem_addr,
    input  logic                                   mem_ack,
    input  logic [addr_width-1:0]                  mem_rdata,
    output logic                                   refill_valid,
    output logic [addr_width-page_offset_bits-1:0] refill_vpn,
    output logic [addr_width-page_offset_bits-1:0] refill_ppn,
    output logic                                   refill_fault,
    output logic                                   timeout_err
);
    localparam int vpn_width  = addr_width - page_offset_bits;
    localparam int level_bits = vpn_width / 2;

    typedef enum logic [1:0] {IDLE, L1, L0, DONE} state_t;

    state_t                 state;
    logic [vpn_width-1:0]   vpn_q;
    logic                   discard;

    logic                   pte_v;
    logic                   pte_l;
    logic [vpn_width-1:0]   pte_ppn;
    logic [level_bits-1:0]  vpn1_in;
    logic [level_bits-1:0]  vpn0_q;

    logic                   walk_descend;
    logic                   walk_fault;
    logic [vpn_width-1:0]   walk_ppn;
    logic                   timed_out;

    // PTE bits [11:2] and the page offset of the miss address do not affect the walk.
    logic                   unused_bits;

    assign pte_v       = mem_rdata[0];
    assign pte_l       = mem_rdata[1];
    assign pte_ppn     = mem_rdata[addr_width-1:page_offset_bits];
    assign vpn1_in     = miss_vaddr[addr_width-1 -: level_bits];
    assign vpn0_q      = vpn_q[level_bits-1:0];
    assign unused_bits = ^{mem_rdata[page_offset_bits-1:2], miss_vaddr[page_offset_bits-1:0]};

`ifdef PTW_TIMEOUT_EN
    localparam int                    cnt_width = $clog2(timeout_cycles + 1);
    localparam logic [cnt_width-1:0] cnt_last  = cnt_width'(timeout_cycles - 1);

    logic [cnt_width-1:0] wait_cnt;

    assign timed_out = mem_req && !mem_ack && (wait_cnt == cnt_last);

    // Watchdog: count the cycles an outstanding read waits, and restart on each ack or new request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!mem_req || mem_ack) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    localparam int unused_timeout_cycles = timeout_cycles;

    assign timed_out = 1'b0;
`endif

    // Decode the PTE returned in this cycle for the current level: descend, leaf translation, or fault.
    always_comb begin
        walk_descend = 1'b0;
        walk_fault   = 1'b0;
        walk_ppn     = '0;
        if (state == L1) begin
            if (!pte_v) begin
                walk_fault = 1'b1;
            end else if (!pte_l) begin
                walk_descend = 1'b1;
            end else if (pte_ppn[level_bits-1:0] != '0) begin
                walk_fault = 1'b1;
            end else begin
                walk_ppn = {pte_ppn[vpn_width-1:level_bits], vpn0_q};
            end
        end else begin
            if (pte_v && pte_l) begin
                walk_ppn = pte_ppn;
            end else begin
                walk_fault = 1'b1;
            end
        end
    end

    // Walk sequencing: accept a miss, fetch one PTE per level, then report the result or discard it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            miss_ready   <= 1'b1;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            refill_valid <= 1'b0;
            refill_vpn   <= '0;
            refill_ppn   <= '0;
            refill_fault <= 1'b0;
            timeout_err  <= 1'b0;
            discard      <= 1'b0;
            vpn_q        <= '0;
        end else begin
            refill_valid <= 1'b0;
            if (flush && state != IDLE) begin
                discard <= 1'b1;
            end
            if (timed_out) begin
                timeout_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (miss_valid) begin
                        vpn_q      <= miss_vaddr[addr_width-1:page_offset_bits];
                        mem_req    <= 1'b1;
                        mem_addr   <= {ptbr_ppn, vpn1_in, 2'b00};
                        miss_ready <= 1'b0;
                        state      <= L1;
                    end
                end
                L1, L0: begin
                    if (mem_ack) begin
                        if (discard || flush) begin
                            mem_req    <= 1'b0;
                            miss_ready <= 1'b1;
                            discard    <= 1'b0;
                            state      <= IDLE;
                        end else if (walk_descend) begin
                            mem_addr <= {pte_ppn, vpn0_q, 2'b00};
                            state    <= L0;
                        end else begin
                            mem_req      <= 1'b0;
                            refill_valid <= 1'b1;
                            refill_vpn   <= vpn_q;
                            refill_ppn   <= walk_ppn;
                            refill_fault <= walk_fault;
                            state        <= DONE;
                        end
                    end else if (timed_out) begin
                        mem_req <= 1'b0;
                        if (discard || flush) begin
                            miss_ready <= 1'b1;
                            discard    <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            refill_valid <= 1'b1;
                            refill_vpn   <= vpn_q;
                            refill_ppn   <= '0;
                            refill_fault <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                DONE: begin
                    miss_ready <= 1'b1;
                    discard    <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_page_table_walker.sv
// tb_page_table_walker: scoreboard bench for page_table_walker.
// Each test pushes its expected refills into a queue. A monitor pops one entry
// and compares it whenever refill_valid pulses.
module tb_page_table_walker;

    typedef struct packed {
        logic [19:0] vpn;
        logic [19:0] ppn;
        logic        fault;
    } refill_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] ptbr_ppn = '0;
    logic        flush = 1'b0;
    logic        miss_valid = 1'b0;
    logic        miss_ready;
    logic [31:0] miss_vaddr = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        refill_valid;
    logic [19:0] refill_vpn;
    logic [19:0] refill_ppn;
    logic        refill_fault;
    logic        timeout_err;

    int checks = 0;
    int passes = 0;

    refill_t     sb_q[$];
    logic [31:0] mem[logic [31:0]];

    page_table_walker #(
        .addr_width       (32),
        .page_offset_bits (12),
        .timeout_cycles   (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ptbr_ppn     (ptbr_ppn),
        .flush        (flush),
        .miss_valid   (miss_valid),
        .miss_ready   (miss_ready),
        .miss_vaddr   (miss_vaddr),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .refill_valid (refill_valid),
        .refill_vpn   (refill_vpn),
        .refill_ppn   (refill_ppn),
        .refill_fault (refill_fault),
        .timeout_err  (timeout_err)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Scoreboard monitor: every refill pulse must match the oldest expected entry.
    always @(posedge clk) begin
        refill_t exp_r;
        #1;
        if (refill_valid === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                $display("[TB] FAIL unexpected_refill: got vpn=%h ppn=%h fault=%b, required no refill",
                         refill_vpn, refill_ppn, refill_fault);
            end else begin
                exp_r = sb_q.pop_front();
                if (refill_vpn !== exp_r.vpn || refill_ppn !== exp_r.ppn || refill_fault !== exp_r.fault) begin
                    $display("[TB] FAIL refill_data: got vpn=%h ppn=%h fault=%b, required vpn=%h ppn=%h fault=%b",
                             refill_vpn, refill_ppn, refill_fault, exp_r.vpn, exp_r.ppn, exp_r.fault);
                end else begin
                    passes++;
                end
            end
        end
    end

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    // Drive one miss and serve the memory port with wait_cycles of delay per access.
    // flush_cycle: -1 means no flush; 0 means flush in the same cycle as the miss; >0 means flush in that cycle.
    task automatic run_walk(input string name, input logic [31:0] vaddr, input logic [19:0] root,
                            input logic [31:0] addr1, input logic [31:0] addr2, input int naccess,
                            input int wait_cycles, input int flush_cycle,
                            input logic exp_fault, input logic [19:0] exp_ppn, input int exp_latency);
        logic [31:0] exp_addrs[$];
        logic [31:0] cur_addr;
        refill_t     e;
        int          cyc;
        int          waited;
        int          acks;
        int          refill_cyc;
        int          last_ack_cyc;
        int          exp_acks;
        bit          discarding;
        bit          finished;
        exp_addrs.push_back(addr1);
        if (naccess > 1) exp_addrs.push_back(addr2);
        discarding = (flush_cycle > 0);
        exp_acks   = discarding ? 1 : naccess;
        if (!discarding) begin
            e.vpn = vaddr[31:12];
            e.ppn = exp_ppn;
            e.fault = exp_fault;
            sb_q.push_back(e);
        end
        checks++;
        if (miss_ready !== 1'b1) $display("[TB] FAIL %s miss_ready_start: got %b, required 1", name, miss_ready);
        else passes++;
        miss_valid = 1'b1;
        miss_vaddr = vaddr;
        ptbr_ppn   = root;
        flush      = (flush_cycle == 0);
        cyc = 0; waited = 0; acks = 0; refill_cyc = -1; last_ack_cyc = -1; finished = 0; cur_addr = '0;
        while (!finished && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            miss_valid = 1'b0;
            mem_ack    = 1'b0;
            mem_rdata  = '0;
            flush      = 1'b0;
            if (refill_valid === 1'b1) refill_cyc = cyc;
            if (mem_req === 1'b1) begin
                checks++;
                if (waited == 0) begin
                    if (exp_addrs.size() == 0) begin
                        $display("[TB] FAIL %s extra_access: got mem_addr=%h, required no request", name, mem_addr);
                    end else if (mem_addr !== exp_addrs[0]) begin
                        $display("[TB] FAIL %s mem_addr: got %h, required %h", name, mem_addr, exp_addrs[0]);
                    end else begin
                        passes++;
                    end
                    cur_addr = mem_addr;
                end else begin
                    if (mem_addr !== cur_addr) $display("[TB] FAIL %s addr_stable: got %h, required %h", name, mem_addr, cur_addr);
                    else passes++;
                end
                if (flush_cycle == cyc) flush = 1'b1;
                if (waited == wait_cycles) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_read(mem_addr);
                    if (exp_addrs.size() > 0) void'(exp_addrs.pop_front());
                    acks++;
                    waited = 0;
                    last_ack_cyc = cyc;
                end else begin
                    waited++;
                end
            end else if (miss_ready === 1'b1) begin
                finished = 1;
            end
        end
        checks++;
        if (!finished) $display("[TB] FAIL %s walk_budget: got no return to idle in %0d cycles, required return", name, cyc);
        else passes++;
        checks++;
        if (acks != exp_acks) $display("[TB] FAIL %s access_count: got %0d, required %0d", name, acks, exp_acks);
        else passes++;
        if (discarding) begin
            checks++;
            if (refill_cyc != -1 || cyc != last_ack_cyc + 1)
                $display("[TB] FAIL %s discard: got refill_cyc=%0d ready_cyc=%0d, required no refill and ready at %0d",
                         name, refill_cyc, cyc, last_ack_cyc + 1);
            else passes++;
        end else begin
            checks++;
            if (refill_cyc + 1 != exp_latency)
                $display("[TB] FAIL %s latency: got %0d cycles, required %0d", name, refill_cyc + 1, exp_latency);
            else passes++;
            checks++;
            if (cyc != refill_cyc + 1) $display("[TB] FAIL %s ready_after_done: got cycle %0d, required %0d", name, cyc, refill_cyc + 1);
            else passes++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (miss_ready !== 1'b1 || mem_req !== 1'b0 || mem_addr !== 32'h0)
            $display("[TB] FAIL reset_port: got ready=%b req=%b addr=%h, required 1 0 0", miss_ready, mem_req, mem_addr);
        else passes++;
        checks++;
        if (refill_valid !== 1'b0 || refill_vpn !== 20'h0 || refill_ppn !== 20'h0 || refill_fault !== 1'b0 || timeout_err !== 1'b0)
            $display("[TB] FAIL reset_refill: got v=%b vpn=%h ppn=%h f=%b to=%b, required all 0",
                     refill_valid, refill_vpn, refill_ppn, refill_fault, timeout_err);
        else passes++;
        rst = 1'b0;
    endtask

    task automatic test_two_level();
        mem.delete();
        mem[32'h00010004] = 32'h00020001;
        mem[32'h0002000C] = 32'h12345003;
        mem[32'h00010FFC] = 32'h00050001;
        mem[32'h00050004] = 32'hFEDCB003;
        run_walk("two_level_max_vpn1", 32'hFFC01234, 20'h00010, 32'h00010FFC, 32'h00050004, 2, 0, -1, 1'b0, 20'hFEDCB, 4);
        run_walk("two_level", 32'h00403ABC, 20'h00010, 32'h00010004, 32'h0002000C, 2, 0, -1, 1'b0, 20'h12345, 4);
        repeat (3) begin
            @(posedge clk); #1;
        end
        checks++;
        if (refill_valid !== 1'b0 || refill_vpn !== 20'h00403 || refill_ppn !== 20'h12345)
            $display("[TB] FAIL refill_hold: got v=%b vpn=%h ppn=%h, required 0 00403 12345", refill_valid, refill_vpn, refill_ppn);
        else passes++;
    endtask

    task automatic test_superpage();
        mem.delete();
        mem[32'h00010004] = 32'h0AC00003;
        run_walk("superpage", 32'h00403ABC, 20'h00010, 32'h00010004, 32'h0, 1, 0, -1, 1'b0, 20'h0AC03, 3);
        mem[32'h00010004] = 32'h0AB00003;
        run_walk("superpage_misaligned", 32'h00403ABC, 20'h00010, 32'h00010004, 32'h0, 1, 0, -1, 1'b1, 20'h0, 3);
    endtask

    task automatic test_faults();
        mem.delete();
        mem[32'h00010004] = 32'h00000000;
        run_walk("fault_l1_invalid", 32'h00403ABC, 20'h00010, 32'h00010004, 32'h0, 1, 0, -1, 1'b1, 20'h0, 3);
        mem[32'h00010004] = 32'h00020001;
        mem[32'h0002000C] = 32'h00030001;
        run_walk("fault_l0_nonleaf", 32'h00403ABC, 20'h00010, 32'h00010004, 32'h0002000C, 2, 0, -1, 1'b1, 20'h0, 4);
    endtask

    task automatic test_flush();
        mem.delete();
        mem[32'h00010004] = 32'h00020001;
        mem[32'h0002000C] = 32'h12345003;
        run_walk("flush_l1_wait", 32'h00403ABC, 20'h00010, 32'h00010004, 32'h0002000C, 2, 5, 2, 1'b0, 20'h0, 0);
        run_walk("after_flush_wait5", 32'h00403ABC, 20'h00010, 32'h00010004, 32'h0002000C, 2, 5, -1, 1'b0, 20'h12345, 14);
        run_walk("flush_with_miss", 32'h00403ABC, 20'h00010, 32'h00010004, 32'h0002000C, 2, 0, 0, 1'b0, 20'h12345, 4);
    endtask

    task automatic test_async_reset();
        bit seen;
        mem.delete();
        mem[32'h00010004] = 32'h00020001;
        mem[32'h0002000C] = 32'h12345003;
        miss_valid = 1'b1;
        miss_vaddr = 32'h00403ABC;
        ptbr_ppn   = 20'h00010;
        @(posedge clk); #1;
        miss_valid = 1'b0;
        mem_ack    = 1'b1;
        mem_rdata  = 32'h00020001;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0002000C)
            $display("[TB] FAIL areset_l0_req: got req=%b addr=%h, required 1 0002000c", mem_req, mem_addr);
        else passes++;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || miss_ready !== 1'b1 || mem_addr !== 32'h0)
            $display("[TB] FAIL areset_port: got req=%b ready=%b addr=%h, required 0 1 0", mem_req, miss_ready, mem_addr);
        else passes++;
        checks++;
        if (refill_vpn !== 20'h0 || refill_ppn !== 20'h0 || refill_fault !== 1'b0 || refill_valid !== 1'b0 || timeout_err !== 1'b0)
            $display("[TB] FAIL areset_refill: got v=%b vpn=%h ppn=%h f=%b to=%b, required all 0",
                     refill_valid, refill_vpn, refill_ppn, refill_fault, timeout_err);
        else passes++;
        @(posedge clk); #1;
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h12345003;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        seen = 0;
        repeat (4) begin
            if (refill_valid === 1'b1 || mem_req === 1'b1) seen = 1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen || miss_ready !== 1'b1)
            $display("[TB] FAIL areset_late_ack: got activity=%b ready=%b, required 0 1", seen, miss_ready);
        else passes++;
        run_walk("after_areset", 32'h00403ABC, 20'h00010, 32'h00010004, 32'h0002000C, 2, 0, -1, 1'b0, 20'h12345, 4);
    endtask

`ifdef PTW_TIMEOUT_EN
    task automatic test_timeout();
        refill_t e;
        int      cyc;
        int      req_cycles;
        int      refill_cyc;
        mem.delete();
        e.vpn = 20'h00403;
        e.ppn = 20'h0;
        e.fault = 1'b1;
        sb_q.push_back(e);
        miss_valid = 1'b1;
        miss_vaddr = 32'h00403ABC;
        ptbr_ppn   = 20'h00010;
        cyc = 0; req_cycles = 0; refill_cyc = -1;
        while (refill_cyc < 0 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            miss_valid = 1'b0;
            if (mem_req === 1'b1) req_cycles++;
            if (refill_valid === 1'b1) refill_cyc = cyc;
        end
        checks++;
        if (req_cycles != 8 || refill_cyc != 9)
            $display("[TB] FAIL timeout_timing: got req_cycles=%0d refill_cyc=%0d, required 8 9", req_cycles, refill_cyc);
        else passes++;
        checks++;
        if (timeout_err !== 1'b1 || mem_req !== 1'b0)
            $display("[TB] FAIL timeout_flag: got err=%b req=%b, required 1 0", timeout_err, mem_req);
        else passes++;
        @(posedge clk); #1;
        mem[32'h00010004] = 32'h00020001;
        mem[32'h0002000C] = 32'h12345003;
        run_walk("after_timeout", 32'h00403ABC, 20'h00010, 32'h00010004, 32'h0002000C, 2, 0, -1, 1'b0, 20'h12345, 4);
        checks++;
        if (timeout_err !== 1'b1) $display("[TB] FAIL timeout_sticky: got %b, required 1", timeout_err);
        else passes++;
        rst = 1'b1;
        #1;
        checks++;
        if (timeout_err !== 1'b0) $display("[TB] FAIL timeout_reset: got %b, required 0", timeout_err);
        else passes++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask
`else
    task automatic test_no_timeout();
        mem.delete();
        mem[32'h00010004] = 32'h00020001;
        mem[32'h0002000C] = 32'h12345003;
        run_walk("long_wait", 32'h00403ABC, 20'h00010, 32'h00010004, 32'h0002000C, 2, 20, -1, 1'b0, 20'h12345, 44);
        checks++;
        if (timeout_err !== 1'b0) $display("[TB] FAIL timeout_tied: got %b, required 0", timeout_err);
        else passes++;
    endtask
`endif

    initial begin
        test_reset();
        test_two_level();
        test_superpage();
        test_faults();
        test_flush();
        test_async_reset();
`ifdef PTW_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) $display("[TB] FAIL missing_refills: got %0d outstanding, required 0", sb_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
